// File: rtl/vga_timing_pkg.sv
// Purpose : shared 640x480@60 raster constants and helpers for the VGA timing block.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package vga_timing_pkg;

  // 640x480@60, 25.175 MHz (25 MHz works with every monitor tried so far).
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  // Both syncs are negative-going in this mode.
  localparam bit HS_POL_DEF   = 1'b0;
  localparam bit VS_POL_DEF   = 1'b0;

  localparam int CNT_W_DEF    = 11;

  // Length of one axis period: active + front porch + sync + back porch.
  function automatic int vga_total(input int active, input int fp,
                                   input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // An axis is usable when every region is at least one unit long and the
  // last count value fits into the counter.
  function automatic bit vga_axis_legal(input int active, input int fp,
                                        input int sync, input int bp,
                                        input int cnt_w);
    longint last;
    last = longint'(vga_total(active, fp, sync, bp)) - 1;
    return (active >= 1) && (fp >= 1) && (sync >= 1) && (bp >= 1) &&
           (cnt_w >= 1) && (cnt_w <= 31) && (last < (longint'(1) << cnt_w));
  endfunction

endpackage

// File: rtl/vga_axis_timer.sv
// Purpose : one raster axis - free-running counter with wrap, active flag and sync window.
// Latency : count is registered; wrap/active/sync are combinational decodes of the current count.
// Backpressure: none; the count advances on every cycle where step is high.
//
// Ports:
//   pixel_clk, rst_n   clock, asynchronous active-low reset
//   step               advance the counter this cycle
//   count [CNT_W]      current position on this axis
//   wrap               count is at TOTAL-1 and step is high (next count is 0)
//   active             count < ACTIVE
//   sync               POL inside ACTIVE+FP <= count < ACTIVE+FP+SYNC, ~POL elsewhere
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP     = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BP     = H_BP_DEF,
  parameter bit POL    = HS_POL_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             pixel_clk,
  input  logic             rst_n,
  input  logic             step,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             active,
  output logic             sync
);

  localparam int               TOTAL    = vga_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_BEG = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(ACTIVE + FP + SYNC);

  logic in_sync;

  assign wrap    = step && (count == LAST);
  assign active  = (count < ACT_END);
  assign in_sync = (count >= SYNC_BEG) && (count < SYNC_END);
  assign sync    = in_sync ? POL : ~POL;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else if (step) begin
      count <= count + CNT_W'(1);
    end
  end

  axis_params_legal: assert property (@(posedge pixel_clk)
      vga_axis_legal(ACTIVE, FP, SYNC, BP, CNT_W))
    else $error("vga_axis_timer: illegal axis parameters (active=%0d fp=%0d sync=%0d bp=%0d cnt_w=%0d)",
                ACTIVE, FP, SYNC, BP, CNT_W);

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose : VGA raster timing - counters, HS/VS, blanking, data-enable and line/frame strobes.
// Latency : every output is registered; outputs at edge k reflect the counter state held before edge k.
// Backpressure: none; free-running from reset release, sinks must keep up with pixel_clk.
//
// Ports:
//   pixel_clk, rst_n       pixel clock, asynchronous active-low reset
//   vga_hs, vga_vs         sync outputs at HS_POL/VS_POL while asserted
//   vga_blank_n            DAC blank, equal to de (low during blanking)
//   vga_sync_n             DAC composite sync, tied low
//   de                     active-video flag
//   x, y [CNT_W]           raw horizontal / vertical counters, blanking included
//   line_start             one-cycle pulse with pixel (0, y) for visible lines
//   frame_start            one-cycle pulse with pixel (0, 0)
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit HS_POL   = HS_POL_DEF,
  parameter bit VS_POL   = VS_POL_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             pixel_clk,
  input  logic             rst_n,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_blank_n,
  output logic             vga_sync_n,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start
);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_wrap;
  logic             h_active;
  logic             v_active;
  logic             h_sync;
  logic             v_sync;
  logic             line_origin;
  logic             frame_origin;
  logic             active_px;

  vga_axis_timer #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HS_POL),
    .CNT_W  (CNT_W)
  ) u_h_axis (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .step      (1'b1),
    .count     (h_cnt),
    .wrap      (h_wrap),
    .active    (h_active),
    .sync      (h_sync)
  );

  // The vertical axis steps once per line, on the horizontal wrap, so a
  // simultaneous wrap of both axes lands on (0, 0).
  vga_axis_timer #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VS_POL),
    .CNT_W  (CNT_W)
  ) u_v_axis (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .step      (h_wrap),
    .count     (v_cnt),
    .wrap      (v_wrap),
    .active    (v_active),
    .sync      (v_sync)
  );

  // Flags that are high exactly while the counters sit at column 0 /
  // pixel (0, 0). They are derived from the wraps one cycle early instead of
  // decoding zero on the full-width counters. Both reset high because the
  // counters reset to (0, 0).
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      line_origin  <= 1'b1;
      frame_origin <= 1'b1;
    end else begin
      line_origin  <= h_wrap;
      frame_origin <= h_wrap & v_wrap;
    end
  end

  assign active_px = h_active & v_active;

  // Single output register stage: every output comes from the same counter
  // state, so nothing is skewed against anything else.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs      <= ~HS_POL;
      vga_vs      <= ~VS_POL;
      de          <= 1'b0;
      vga_blank_n <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vga_hs      <= h_sync;
      vga_vs      <= v_sync;
      de          <= active_px;
      vga_blank_n <= active_px;
      x           <= h_cnt;
      y           <= v_cnt;
      line_start  <= line_origin & v_active;
      frame_start <= frame_origin;
    end
  end

  // Composite sync is not used by the DAC on this board.
  assign vga_sync_n = 1'b0;

  origin_flags_consistent: assert property (@(posedge pixel_clk) disable iff (!rst_n)
      (line_origin == (h_cnt == '0)) && (frame_origin == ((h_cnt == '0) && (v_cnt == '0))))
    else $error("vga_timing_gen: origin flags out of step with counters");

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int CNT_W = 11;

  // Instance 0: small raster, instance 1: defaults, instance 2: small raster, inverted polarity.
  localparam int HA [3] = '{8, 640, 8};
  localparam int HF [3] = '{2, 16, 2};
  localparam int HSW[3] = '{2, 96, 2};
  localparam int HB [3] = '{2, 48, 2};
  localparam int VA [3] = '{4, 480, 4};
  localparam int VF [3] = '{1, 10, 1};
  localparam int VSW[3] = '{1, 2, 1};
  localparam int VB [3] = '{1, 33, 1};
  localparam bit HP [3] = '{1'b0, 1'b0, 1'b1};
  localparam bit VP [3] = '{1'b0, 1'b0, 1'b1};

  typedef struct packed {
    logic             hs;
    logic             vs;
    logic             de;
    logic             blank_n;
    logic             sync_n;
    logic             line_start;
    logic             frame_start;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
  } obs_t;

  logic pixel_clk = 1'b0;
  logic rst_n     = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  logic hs_s, vs_s, bn_s, sn_s, de_s, ls_s, fs_s;
  logic hs_d, vs_d, bn_d, sn_d, de_d, ls_d, fs_d;
  logic hs_p, vs_p, bn_p, sn_p, de_p, ls_p, fs_p;
  logic [CNT_W-1:0] x_s, y_s, x_d, y_d, x_p, y_p;
  obs_t ob_s, ob_d, ob_p;

  assign ob_s = {hs_s, vs_s, de_s, bn_s, sn_s, ls_s, fs_s, x_s, y_s};
  assign ob_d = {hs_d, vs_d, de_d, bn_d, sn_d, ls_d, fs_d, x_d, y_d};
  assign ob_p = {hs_p, vs_p, de_p, bn_p, sn_p, ls_p, fs_p, x_p, y_p};

  vga_timing_gen #(
    .H_ACTIVE(HA[0]), .H_FP(HF[0]), .H_SYNC(HSW[0]), .H_BP(HB[0]),
    .V_ACTIVE(VA[0]), .V_FP(VF[0]), .V_SYNC(VSW[0]), .V_BP(VB[0]),
    .HS_POL(HP[0]), .VS_POL(VP[0]), .CNT_W(CNT_W)
  ) dut_s (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .vga_hs(hs_s), .vga_vs(vs_s),
    .vga_blank_n(bn_s), .vga_sync_n(sn_s), .de(de_s), .x(x_s), .y(y_s),
    .line_start(ls_s), .frame_start(fs_s)
  );

  vga_timing_gen dut_d (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .vga_hs(hs_d), .vga_vs(vs_d),
    .vga_blank_n(bn_d), .vga_sync_n(sn_d), .de(de_d), .x(x_d), .y(y_d),
    .line_start(ls_d), .frame_start(fs_d)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA[2]), .H_FP(HF[2]), .H_SYNC(HSW[2]), .H_BP(HB[2]),
    .V_ACTIVE(VA[2]), .V_FP(VF[2]), .V_SYNC(VSW[2]), .V_BP(VB[2]),
    .HS_POL(HP[2]), .VS_POL(VP[2]), .CNT_W(CNT_W)
  ) dut_p (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .vga_hs(hs_p), .vga_vs(vs_p),
    .vga_blank_n(bn_p), .vga_sync_n(sn_p), .de(de_p), .x(x_p), .y(y_p),
    .line_start(ls_p), .frame_start(fs_p)
  );

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;
  int mh[3]    = '{0, 0, 0};
  int mv[3]    = '{0, 0, 0};
  obs_t sb[3][$];

  // Expected outputs for counter state (h, v), straight from the raster definition.
  function automatic obs_t model_out(input int i, input int h, input int v);
    obs_t e;
    int   hb;
    int   vb;
    hb            = HA[i] + HF[i];
    vb            = VA[i] + VF[i];
    e.hs          = (h >= hb && h < hb + HSW[i]) ? HP[i] : ~HP[i];
    e.vs          = (v >= vb && v < vb + VSW[i]) ? VP[i] : ~VP[i];
    e.de          = (h < HA[i]) && (v < VA[i]);
    e.blank_n     = e.de;
    e.sync_n      = 1'b0;
    e.line_start  = (h == 0) && (v < VA[i]);
    e.frame_start = (h == 0) && (v == 0);
    e.x           = h[CNT_W-1:0];
    e.y           = v[CNT_W-1:0];
    return e;
  endfunction

  // Scoreboard producer: on each clock edge the expected outputs for the
  // counter state held before the edge are queued, then the model advances.
  always @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_n = 0;
      for (int i = 0; i < 3; i++) begin
        mh[i] = 0;
        mv[i] = 0;
        sb[i].delete();
      end
    end else begin
      edge_n++;
      for (int i = 0; i < 3; i++) begin
        sb[i].push_back(model_out(i, mh[i], mv[i]));
        if (mh[i] == HA[i] + HF[i] + HSW[i] + HB[i] - 1) begin
          mh[i] = 0;
          mv[i] = (mv[i] == VA[i] + VF[i] + VSW[i] + VB[i] - 1) ? 0 : mv[i] + 1;
        end else begin
          mh[i] = mh[i] + 1;
        end
      end
    end
  end

  task automatic test_reset();
    obs_t want;
    rst_n = 1'b0;
    repeat (5) @(negedge pixel_clk);
    want = '0; want.hs = 1'b1; want.vs = 1'b1;
    checks++;
    if (ob_s !== want) begin failures++; $display("FAIL reset_small got=%h want=%h", ob_s, want); end
    checks++;
    if (ob_d !== want) begin failures++; $display("FAIL reset_default got=%h want=%h", ob_d, want); end
    want.hs = 1'b0; want.vs = 1'b0;
    checks++;
    if (ob_p !== want) begin failures++; $display("FAIL reset_pol got=%h want=%h", ob_p, want); end
    rst_n = 1'b1;
    @(negedge pixel_clk);
    want = '0; want.hs = 1'b1; want.vs = 1'b1; want.de = 1'b1; want.blank_n = 1'b1;
    want.line_start = 1'b1; want.frame_start = 1'b1;
    checks++;
    if (ob_s !== want) begin failures++; $display("FAIL first_edge_small got=%h want=%h", ob_s, want); end
    checks++;
    if (ob_d !== want) begin failures++; $display("FAIL first_edge_default got=%h want=%h", ob_d, want); end
  endtask

  task automatic test_small_raster();
    obs_t e;
    int   px = 0, py = 0, want_y;
    bit   have_prev = 1'b0;
    int   n_hs = 0, n_vs = 0, n_de = 0, n_ls = 0, n_fs = 0;
    @(negedge pixel_clk);
    sb[0].delete();
    for (int c = 0; c < 294; c++) begin
      @(negedge pixel_clk);
      checks++;
      if (sb[0].size() == 0) begin
        failures++; $display("FAIL sb_small underflow at edge %0d", edge_n);
      end else begin
        e = sb[0].pop_front();
        if (ob_s !== e) begin
          failures++;
          $display("FAIL sb_small edge=%0d got x=%0d y=%0d hs=%b vs=%b de=%b bn=%b sn=%b ls=%b fs=%b want x=%0d y=%0d hs=%b vs=%b de=%b bn=%b sn=%b ls=%b fs=%b",
                   edge_n, x_s, y_s, hs_s, vs_s, de_s, bn_s, sn_s, ls_s, fs_s,
                   e.x, e.y, e.hs, e.vs, e.de, e.blank_n, e.sync_n, e.line_start, e.frame_start);
        end
      end
      if (have_prev && px == 13) begin
        want_y = (py == 6) ? 0 : py + 1;
        checks++;
        if ({x_s, y_s, fs_s} !== {CNT_W'(0), CNT_W'(want_y), (py == 6)}) begin
          failures++;
          $display("FAIL small_wrap after (13,%0d) got x=%0d y=%0d fs=%b want x=0 y=%0d fs=%b",
                   py, x_s, y_s, fs_s, want_y, (py == 6));
        end
      end
      n_hs += (hs_s === 1'b0) ? 1 : 0;
      n_vs += (vs_s === 1'b0) ? 1 : 0;
      n_de += (de_s === 1'b1) ? 1 : 0;
      n_ls += (ls_s === 1'b1) ? 1 : 0;
      n_fs += (fs_s === 1'b1) ? 1 : 0;
      px = int'(x_s);
      py = int'(y_s);
      have_prev = 1'b1;
    end
    // Three whole 98-cycle frames.
    checks++;
    if (n_hs != 42) begin failures++; $display("FAIL small_hs_low_cycles got=%0d want=42", n_hs); end
    checks++;
    if (n_vs != 42) begin failures++; $display("FAIL small_vs_low_cycles got=%0d want=42", n_vs); end
    checks++;
    if (n_de != 96) begin failures++; $display("FAIL small_de_cycles got=%0d want=96", n_de); end
    checks++;
    if (n_ls != 12) begin failures++; $display("FAIL small_line_starts got=%0d want=12", n_ls); end
    checks++;
    if (n_fs != 3) begin failures++; $display("FAIL small_frame_starts got=%0d want=3", n_fs); end
  endtask

  task automatic test_polarity();
    obs_t e;
    int   n_hs = 0, n_vs = 0;
    @(negedge pixel_clk);
    sb[2].delete();
    for (int c = 0; c < 196; c++) begin
      @(negedge pixel_clk);
      checks++;
      if (sb[2].size() == 0) begin
        failures++; $display("FAIL sb_pol underflow at edge %0d", edge_n);
      end else begin
        e = sb[2].pop_front();
        if (ob_p !== e) begin
          failures++;
          $display("FAIL sb_pol edge=%0d got x=%0d y=%0d hs=%b vs=%b de=%b fs=%b want x=%0d y=%0d hs=%b vs=%b de=%b fs=%b",
                   edge_n, x_p, y_p, hs_p, vs_p, de_p, fs_p, e.x, e.y, e.hs, e.vs, e.de, e.frame_start);
        end
      end
      n_hs += (hs_p === 1'b1) ? 1 : 0;
      n_vs += (vs_p === 1'b1) ? 1 : 0;
    end
    checks++;
    if (n_hs != 28) begin failures++; $display("FAIL pol_hs_high_cycles got=%0d want=28", n_hs); end
    checks++;
    if (n_vs != 28) begin failures++; $display("FAIL pol_vs_high_cycles got=%0d want=28", n_vs); end
  endtask

  task automatic test_horizontal_default();
    obs_t e;
    logic prev_hs = 1'b1;
    int   fall_edge = -1, last_ls = -1, n_de = 0, n_ls = 0;
    @(negedge pixel_clk);
    sb[1].delete();
    prev_hs = hs_d;
    for (int c = 0; c < 2400; c++) begin
      @(negedge pixel_clk);
      checks++;
      if (sb[1].size() == 0) begin
        failures++; $display("FAIL sb_default underflow at edge %0d", edge_n);
      end else begin
        e = sb[1].pop_front();
        if (ob_d !== e) begin
          failures++;
          $display("FAIL sb_default edge=%0d got x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b want x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b",
                   edge_n, x_d, y_d, hs_d, vs_d, de_d, ls_d, fs_d,
                   e.x, e.y, e.hs, e.vs, e.de, e.line_start, e.frame_start);
        end
      end
      if (prev_hs === 1'b1 && hs_d === 1'b0) begin
        fall_edge = edge_n;
        checks++;
        if (edge_n % 800 != 657) begin failures++; $display("FAIL hs_fall_edge got=%0d want=657 mod 800", edge_n); end
      end
      if (prev_hs === 1'b0 && hs_d === 1'b1 && fall_edge >= 0) begin
        checks++;
        if (edge_n - fall_edge != 96) begin failures++; $display("FAIL hs_width got=%0d want=96", edge_n - fall_edge); end
      end
      if (ls_d === 1'b1) begin
        if (last_ls >= 0) begin
          checks++;
          if (edge_n - last_ls != 800) begin failures++; $display("FAIL line_start_period got=%0d want=800", edge_n - last_ls); end
        end
        last_ls = edge_n;
      end
      n_de += (de_d === 1'b1) ? 1 : 0;
      n_ls += (ls_d === 1'b1) ? 1 : 0;
      prev_hs = hs_d;
    end
    checks++;
    if (n_de != 1920) begin failures++; $display("FAIL default_de_cycles got=%0d want=1920", n_de); end
    checks++;
    if (n_ls != 3) begin failures++; $display("FAIL default_line_starts got=%0d want=3", n_ls); end
  endtask

  task automatic test_mid_frame_reset();
    obs_t want, e;
    bit   found = 1'b0;
    logic prev_hs;
    int   n_fall = 0;
    for (int c = 0; c < 1000 && !found; c++) begin
      @(negedge pixel_clk);
      if (x_d == CNT_W'(300) && y_d != '0) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL mid_reset_wait got=timeout want=x 300 reached"); end
    #2 rst_n = 1'b0;
    #1;
    want = '0; want.hs = 1'b1; want.vs = 1'b1;
    checks++;
    if (ob_d !== want) begin failures++; $display("FAIL mid_reset_default got=%h want=%h", ob_d, want); end
    checks++;
    if (ob_s !== want) begin failures++; $display("FAIL mid_reset_small got=%h want=%h", ob_s, want); end
    want.hs = 1'b0; want.vs = 1'b0;
    checks++;
    if (ob_p !== want) begin failures++; $display("FAIL mid_reset_pol got=%h want=%h", ob_p, want); end
    repeat (3) @(negedge pixel_clk);
    rst_n = 1'b1;
    @(negedge pixel_clk);
    want = '0; want.hs = 1'b1; want.vs = 1'b1; want.de = 1'b1; want.blank_n = 1'b1;
    want.line_start = 1'b1; want.frame_start = 1'b1;
    checks++;
    if (ob_d !== want) begin failures++; $display("FAIL mid_reset_first_edge got=%h want=%h", ob_d, want); end
    sb[1].delete();
    prev_hs = hs_d;
    for (int c = 0; c < 1700; c++) begin
      @(negedge pixel_clk);
      checks++;
      if (sb[1].size() == 0) begin
        failures++; $display("FAIL sb_restart underflow at edge %0d", edge_n);
      end else begin
        e = sb[1].pop_front();
        if (ob_d !== e) begin
          failures++;
          $display("FAIL sb_restart edge=%0d got x=%0d y=%0d hs=%b de=%b want x=%0d y=%0d hs=%b de=%b",
                   edge_n, x_d, y_d, hs_d, de_d, e.x, e.y, e.hs, e.de);
        end
      end
      if (prev_hs === 1'b1 && hs_d === 1'b0) begin
        n_fall++;
        checks++;
        if (edge_n != 657 + 800 * (n_fall - 1)) begin
          failures++; $display("FAIL restart_hs_fall got=%0d want=%0d", edge_n, 657 + 800 * (n_fall - 1));
        end
      end
      prev_hs = hs_d;
    end
    checks++;
    if (n_fall != 2) begin failures++; $display("FAIL restart_hs_fall_count got=%0d want=2", n_fall); end
  endtask

  initial begin
    test_reset();
    test_small_raster();
    test_polarity();
    test_horizontal_default();
    test_mid_frame_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=bench complete");
    $fatal(1, "watchdog expired");
  end

endmodule
